argmax_seq: RTL and testbench
=============================

Name: argmax_seq

Overview:
- Downstream consumer of the parallel neural layer's OUT_SIZE-wide result bus (IEEE-754 single-precision, element i at bits [32*i +: 32]).
- Captures one result vector per handshake and scans it sequentially, one element per clock.
- Returns the index and value of the maximum element, i.e. the classification decision of the network's final layer.
- Sequential design keeps area at a single float comparator, independent of VLEN.

Parameters:
- VLEN, 1, number of 32-bit float elements in the input vector; must match the upstream layer's OUT_SIZE.
- IDX_W (localparam, not overridable), max(1, $clog2(VLEN)), width of the index output.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_vec  input  32*VLEN  result vector from upstream layer; element i at [32*i +: 32].
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- out_index  output  IDX_W  index of the maximum element.
- out_value  output  32  float value of the maximum element.
- out_all_nan  output  1  every element was NaN.
- out_valid  output  1  outputs valid; held until consumed.
- out_ready  input  1  downstream consumes result.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, out_index=0, out_value=0, out_all_nan=0. Reset overrides every other event, including mid-SCAN; a partially scanned vector is discarded and produces no output.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: register in_vec; best_val=elem0; best_idx=0; scan_idx=1. Next state is SCAN if VLEN>1, else DONE.
  - SCAN: in_ready=0. Each cycle compares elem[scan_idx] against best_val, updates best_val/best_idx if the element wins, and increments scan_idx. After elem[VLEN-1] is processed, next state is DONE.
  - DONE: out_valid=1; outputs stable and in_ready=0. On out_ready=1 go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises VLEN-1 edges after the accept edge; for VLEN=1 it rises on the accept edge itself.
- Throughput: one vector per VLEN+1 cycles minimum. No same-cycle output-consume/input-accept overlap.
- in_vec is sampled only on the accept edge. Later changes to in_vec and in_valid are ignored until IDLE.
- out_ready outside DONE is ignored.
- Float ordering ("a beats b", strict):
  - NaN = exponent 0xFF with mantissa != 0. A NaN never beats anything. A non-NaN beats a NaN best.
  - +0 and -0 compare equal.
  - Different signs, non-zero: the positive value wins.
  - Both positive: the larger magnitude field ([30:0]) wins.
  - Both negative: the smaller magnitude field wins.
  - ±Inf are ordered by the same rules.
- Ties keep the lower index; replacement requires a strict win.
- out_all_nan=1 if every element is NaN. In that case out_index=0 and out_value=elem0.
- No pipelining of the comparator. The compare and update of one element complete in the same cycle (combinational compare, registered result).

Test Plan:
- VLEN=4, in_vec={3F800000, 40000000, BF800000, 3F000000} (elements 0..3) -> out_index=1, out_value=40000000, out_all_nan=0; out_valid rises exactly 3 edges after accept.
- VLEN=4, all elements 3F800000 (tie) -> out_index=0; then {BF800000, C0000000, BF000000, C0400000} (all negative) -> out_index=2, out_value=BF000000.
- VLEN=4, {7FC00000, 80000000, 7FC00000, 00000000} -> out_index=1, out_value=80000000 (NaN skipped, ±0 tie keeps lower index); all elements 7FC00000 -> out_all_nan=1, out_index=0, out_value=7FC00000.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0, a new in_valid is ignored; raise out_ready -> IDLE next cycle, then the next vector is accepted.
- Reset mid-SCAN (VLEN=8, rst asserted at scan_idx=3) -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; no out_valid for the aborted vector. A fresh vector then completes normally.
- VLEN=1, in_vec=FF800000 (-Inf) -> out_valid on the accept edge, out_index=0, out_value=FF800000.

Source files
------------

// File: rtl/argmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : argmax_seq
// Purpose  : Captures one float32 result vector per handshake, scans it one
//            element per clock and reports the index/value of the maximum.
// Revision : 1.0 - initial release
// ============================================================================
module argmax_seq #(
    parameter int VLEN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*VLEN-1:0]     in_vec,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [((VLEN > 1) ? $clog2(VLEN) : 1)-1:0] out_index,
    output logic [31:0]            out_value,
    output logic                   out_all_nan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(VLEN - 1);
    localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

    logic [1:0]         r_state_q,    w_state_d;
    logic [32*VLEN-1:0] r_vec_q,      w_vec_d;
    logic [31:0]        r_best_val_q, w_best_val_d;
    logic [IDX_W-1:0]   r_best_idx_q, w_best_idx_d;
    logic [IDX_W-1:0]   r_scan_idx_q, w_scan_idx_d;

    logic [31:0]        w_elems [VLEN];
    logic [31:0]        w_cand;
    logic               w_wins;

    function automatic logic f_is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Strict "a beats b": NaN never wins, +0/-0 tie, negatives order by
    // inverted magnitude.
    function automatic logic f_beats(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (f_is_nan(a))                                r = 1'b0;
        else if (f_is_nan(b))                           r = 1'b1;
        else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) r = 1'b0;
        else if (a[31] != b[31])                        r = ~a[31];
        else if (!a[31])                                r = (a[30:0] > b[30:0]);
        else                                            r = (a[30:0] < b[30:0]);
        return r;
    endfunction

    for (genvar gi = 0; gi < VLEN; gi++) begin : g_unpack
        assign w_elems[gi] = r_vec_q[32*gi +: 32];
    end

    if (VLEN == 1) begin : g_single
        assign w_cand = w_elems[0];
    end else begin : g_multi
        assign w_cand = w_elems[r_scan_idx_q];
    end

    assign w_wins = f_beats(w_cand, r_best_val_q);

    always_comb begin
        w_state_d    = r_state_q;
        w_vec_d      = r_vec_q;
        w_best_val_d = r_best_val_q;
        w_best_idx_d = r_best_idx_q;
        w_scan_idx_d = r_scan_idx_q;
        case (r_state_q)
            c_IDLE: begin
                if (in_valid) begin
                    w_vec_d      = in_vec;
                    w_best_val_d = in_vec[31:0];
                    w_best_idx_d = '0;
                    w_scan_idx_d = c_ONE;
                    w_state_d    = (VLEN > 1) ? c_SCAN : c_DONE;
                end
            end
            c_SCAN: begin
                if (w_wins) begin
                    w_best_val_d = w_cand;
                    w_best_idx_d = r_scan_idx_q;
                end
                w_scan_idx_d = r_scan_idx_q + c_ONE;
                if (r_scan_idx_q == c_LAST) begin
                    w_state_d = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_d = c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_IDLE;
            r_vec_q      <= '0;
            r_best_val_q <= '0;
            r_best_idx_q <= '0;
            r_scan_idx_q <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_vec_q      <= w_vec_d;
            r_best_val_q <= w_best_val_d;
            r_best_idx_q <= w_best_idx_d;
            r_scan_idx_q <= w_scan_idx_d;
        end
    end

    // The best value can only remain NaN if every element seen so far was NaN.
    assign in_ready    = (r_state_q == c_IDLE);
    assign out_valid   = (r_state_q == c_DONE);
    assign out_index   = r_best_idx_q;
    assign out_value   = r_best_val_q;
    assign out_all_nan = f_is_nan(r_best_val_q);

endmodule
`default_nettype wire

// File: tb/tb_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_seq
// Purpose  : Self-checking bench for argmax_seq with VLEN = 1, 4 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         out_ready = 1'b0;

    logic [31:0]  in_vec1 = '0;
    logic [127:0] in_vec4 = '0;
    logic [255:0] in_vec8 = '0;
    logic         in_valid1 = 1'b0, in_valid4 = 1'b0, in_valid8 = 1'b0;
    logic         ir1, ir4, ir8, ov1, ov4, ov8, nan1, nan4, nan8;
    logic [0:0]   oi1;
    logic [1:0]   oi4;
    logic [2:0]   oi8;
    logic [31:0]  val1, val4, val8;

    int           cur_n = 4;
    logic         cur_valid, cur_in_ready, cur_nan;
    logic [7:0]   cur_idx;
    logic [31:0]  cur_val;

    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    argmax_seq #(.VLEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_vec(in_vec1), .in_valid(in_valid1), .in_ready(ir1),
        .out_index(oi1), .out_value(val1), .out_all_nan(nan1), .out_valid(ov1),
        .out_ready(out_ready)
    );
    argmax_seq #(.VLEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_vec(in_vec4), .in_valid(in_valid4), .in_ready(ir4),
        .out_index(oi4), .out_value(val4), .out_all_nan(nan4), .out_valid(ov4),
        .out_ready(out_ready)
    );
    argmax_seq #(.VLEN(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_vec(in_vec8), .in_valid(in_valid8), .in_ready(ir8),
        .out_index(oi8), .out_value(val8), .out_all_nan(nan8), .out_valid(ov8),
        .out_ready(out_ready)
    );

    always_comb begin
        cur_valid = ov4; cur_in_ready = ir4; cur_nan = nan4;
        cur_idx = 8'(oi4); cur_val = val4;
        case (cur_n)
            1: begin
                cur_valid = ov1; cur_in_ready = ir1; cur_nan = nan1;
                cur_idx = 8'(oi1); cur_val = val1;
            end
            8: begin
                cur_valid = ov8; cur_in_ready = ir8; cur_nan = nan8;
                cur_idx = 8'(oi8); cur_val = val8;
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: map each non-NaN float to a signed integer key (sign applied
    // to the magnitude field) and take the first strictly largest key.
    task automatic model(input int n, input logic [255:0] v,
                         output int idx, output logic [31:0] val, output logic nan);
        longint best = 0;
        bit     found = 0;
        idx = 0;
        val = v[31:0];
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            longint      key;
            e = v[32*i +: 32];
            if (e[30:23] == 8'hFF && e[22:0] != 0) continue;
            key = e[31] ? -longint'(e[30:0]) : longint'(e[30:0]);
            if (!found || key > best) begin
                found = 1;
                best  = key;
                idx   = i;
                val   = e;
            end
        end
        nan = !found;
    endtask

    function automatic logic [31:0] rand_elem();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r = {r[31], 8'hFF, r[22:0] | 23'd1};
            1: r = {r[31], 31'd0};
            2: r = {r[31], 8'hFF, 23'd0};
            3: r = r[0] ? 32'h3F800000 : 32'hBF800000;
            default: ;
        endcase
        return r;
    endfunction

    // Call #1 after an edge with the selected instance idle.
    task automatic apply(input int n, input logic [255:0] v, input int eidx,
                         input logic [31:0] eval, input logic enan, input string tag);
        int lat;
        cur_n = n;
        #0;
        check({tag, " ready"}, 64'(cur_in_ready), 64'd1);
        case (n)
            1: begin in_vec1 = v[31:0];  in_valid1 = 1'b1; end
            4: begin in_vec4 = v[127:0]; in_valid4 = 1'b1; end
            default: begin in_vec8 = v; in_valid8 = 1'b1; end
        endcase
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_valid4 = 1'b0; in_valid8 = 1'b0;
        lat = 0;
        while (!cur_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(n - 1));
        check({tag, " index"}, 64'(cur_idx), 64'(eidx));
        check({tag, " value"}, 64'(cur_val), 64'(eval));
        check({tag, " all_nan"}, 64'(cur_nan), 64'(enan));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " consumed"}, {62'd0, cur_valid, cur_in_ready}, 64'b01);
    endtask

    typedef struct {
        logic [127:0] vec;
        int           idx;
        logic [31:0]  val;
        logic         nan;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          ridx;
        logic [31:0] rval;
        logic        rnan;
        logic [255:0] v;

        tbl[0] = '{vec: 128'h3F000000_BF800000_40000000_3F800000, idx: 1, val: 32'h40000000, nan: 1'b0};
        tbl[1] = '{vec: 128'h3F800000_3F800000_3F800000_3F800000, idx: 0, val: 32'h3F800000, nan: 1'b0};
        tbl[2] = '{vec: 128'hC0400000_BF000000_C0000000_BF800000, idx: 2, val: 32'hBF000000, nan: 1'b0};
        tbl[3] = '{vec: 128'h00000000_7FC00000_80000000_7FC00000, idx: 1, val: 32'h80000000, nan: 1'b0};
        tbl[4] = '{vec: 128'h7FC00000_7FC00000_7FC00000_7FC00000, idx: 0, val: 32'h7FC00000, nan: 1'b1};
        tbl[5] = '{vec: 128'h7FC00001_FF800000_7F7FFFFF_7F800000, idx: 0, val: 32'h7F800000, nan: 1'b0};
        tbl[6] = '{vec: 128'hFF7FFFFF_FF800000_7FC00000_FF800000, idx: 3, val: 32'hFF7FFFFF, nan: 1'b0};
        tbl[7] = '{vec: 128'h3F800000_FFC00000_7F800001_7FC00000, idx: 3, val: 32'h3F800000, nan: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset vlen4", {26'd0, ov4, ir4, oi4, val4, nan4}, {26'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0});
        check("reset vlen8", {25'd0, ov8, ir8, oi8, val8, nan8}, {25'd0, 1'b0, 1'b1, 3'd0, 32'd0, 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            apply(4, {128'd0, tbl[i].vec}, tbl[i].idx, tbl[i].val, tbl[i].nan, $sformatf("table%0d", i));
        end

        apply(1, {224'd0, 32'hFF800000}, 0, 32'hFF800000, 1'b0, "vlen1 -inf");
        apply(1, {224'd0, 32'h7FC00000}, 0, 32'h7FC00000, 1'b1, "vlen1 nan");

        // Back-pressure: result held, new request ignored until consumed.
        cur_n = 4;
        in_vec4 = tbl[0].vec; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp valid", 64'(ov4), 64'd1);
        in_vec4 = tbl[2].vec; in_valid4 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d", c), {28'd0, ov4, ir4, oi4, val4},
                  {28'd0, 1'b1, 1'b0, 2'd1, 32'h40000000});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp consume", {62'd0, ov4, ir4}, 64'b01);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check("bp accept", 64'(ir4), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp second", {29'd0, ov4, oi4, val4}, {29'd0, 1'b1, 2'd2, 32'hBF000000});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset arriving on the edge where scan index is 3.
        cur_n = 8;
        in_vec8 = {8{32'h3F800000}};
        in_vec8[32*5 +: 32] = 32'h40400000;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midscan reset", {25'd0, ov8, ir8, oi8, val8, nan8}, {25'd0, 1'b0, 1'b1, 3'd0, 32'd0, 1'b0});
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (ov8) seen++;
            end
            check("midscan no output", 64'(seen), 64'd0);
        end
        apply(8, {8{32'hBF800000}}, 0, 32'hBF800000, 1'b0, "post reset");

        for (int r = 0; r < 30; r++) begin
            int n;
            n = (r % 3 == 0) ? 4 : 8;
            v = '0;
            for (int i = 0; i < n; i++) v[32*i +: 32] = rand_elem();
            model(n, v, ridx, rval, rnan);
            apply(n, v, ridx, rval, rnan, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
